// File: rtl/wptr_full_ctrl_if.sv
// Write-side FIFO controller bus: write request, synchronised read pointer,
// flag configuration in; write address, Gray pointer and flags out.
interface wptr_full_ctrl_if #(
  parameter int ADDRSIZE = 7
);
  logic                w_en;
  logic [ADDRSIZE:0]   r2wptr;
  logic [ADDRSIZE:0]   af_thresh;
  logic                ovf_clr;
  logic [ADDRSIZE-1:0] waddr;
  logic [ADDRSIZE:0]   wptr_gray;
  logic                w_ack;
  logic                wfull;
  logic                walmost_full;
  logic [ADDRSIZE:0]   wlevel;
  logic                wovf;

  modport master (
    output w_en, r2wptr, af_thresh, ovf_clr,
    input  waddr, wptr_gray, w_ack, wfull, walmost_full, wlevel, wovf
  );

  modport slave (
    input  w_en, r2wptr, af_thresh, ovf_clr,
    output waddr, wptr_gray, w_ack, wfull, walmost_full, wlevel, wovf
  );
endinterface

// File: rtl/wptr_full_ctrl.sv
// Async FIFO write-side pointer/flag controller. All flags are derived from the
// next-state write pointer so they are exact on the edge that changes occupancy.
module wptr_full_ctrl #(
  parameter int ADDRSIZE = 7
) (
  input  logic wclk,
  input  logic wrst,
  wptr_full_ctrl_if.slave bus
);

  localparam int PW = ADDRSIZE + 1;

  logic [PW-1:0] wptr_bin_q,  wptr_bin_d;
  logic [PW-1:0] wptr_gray_q, wptr_gray_d;
  logic [PW-1:0] wlevel_q,    wlevel_d;
  logic          wfull_q,        wfull_d;
  logic          walmost_full_q, walmost_full_d;
  logic          wovf_q,         wovf_d;
  logic          w_ack;
  logic [PW-1:0] rbin;
  logic [PW-1:0] full_gray;

  // NOTE: every always_comb output gets a default first, so no path can leave a
  // value unassigned and infer a latch; combinational logic uses blocking '='.
  always_comb begin
    w_ack          = 1'b0;
    rbin           = '0;
    full_gray      = '0;
    wptr_bin_d     = wptr_bin_q;
    wptr_gray_d    = wptr_gray_q;
    wlevel_d       = wlevel_q;
    wfull_d        = wfull_q;
    walmost_full_d = walmost_full_q;
    wovf_d         = wovf_q;

    // Writes are gated by the registered full flag and never leak through reset.
    w_ack = bus.w_en && !wfull_q && !wrst;

    // Gray-to-binary: bit i is the XOR of all Gray bits at or above i.
    for (int i = 0; i < PW; i++) begin
      rbin[i] = ^(bus.r2wptr >> i);
    end

    wptr_bin_d  = wptr_bin_q + PW'(w_ack);
    wptr_gray_d = (wptr_bin_d >> 1) ^ wptr_bin_d;

    // Full when the write pointer is exactly one lap ahead of the read pointer.
    full_gray      = {~bus.r2wptr[ADDRSIZE:ADDRSIZE-1], bus.r2wptr[ADDRSIZE-2:0]};
    wfull_d        = (wptr_gray_d == full_gray);
    wlevel_d       = wptr_bin_d - rbin;
    walmost_full_d = (wlevel_d >= bus.af_thresh);

    // Set has priority over clear so a concurrent overflow is never lost.
    if (bus.w_en && wfull_q) begin
      wovf_d = 1'b1;
    end else if (bus.ovf_clr) begin
      wovf_d = 1'b0;
    end
  end

  // NOTE: sequential state is updated with non-blocking '<=' only, so every flop
  // samples the pre-edge values of all the others.
  always_ff @(posedge wclk) begin
    if (wrst) begin
      wptr_bin_q     <= '0;
      wptr_gray_q    <= '0;
      wlevel_q       <= '0;
      wfull_q        <= 1'b0;
      walmost_full_q <= 1'b0;
      wovf_q         <= 1'b0;
    end else begin
      wptr_bin_q     <= wptr_bin_d;
      wptr_gray_q    <= wptr_gray_d;
      wlevel_q       <= wlevel_d;
      wfull_q        <= wfull_d;
      walmost_full_q <= walmost_full_d;
      wovf_q         <= wovf_d;
    end
  end

  assign bus.waddr        = wptr_bin_q[ADDRSIZE-1:0];
  assign bus.wptr_gray    = wptr_gray_q;
  assign bus.w_ack        = w_ack;
  assign bus.wfull        = wfull_q;
  assign bus.walmost_full = walmost_full_q;
  assign bus.wlevel       = wlevel_q;
  assign bus.wovf         = wovf_q;

endmodule

// File: doc/wptr_full_ctrl.md
# wptr_full_ctrl

Parametrised write-side pointer and flag controller for the asynchronous FIFO, the successor to the basic write/full block. It runs in the write clock domain and maintains the binary write address and the registered Gray write pointer for the synchroniser. It takes the read pointer already synchronised into the write domain and produces full, programmable almost-full, a fill-level count and a sticky overflow flag. All flags are computed from next-state pointers, so they are exact on the edge that changes occupancy.

## Interface
- ADDRSIZE, 7, memory address width; FIFO depth = 2^ADDRSIZE; legal range ≥ 2
- wclk  input  1  write clock; all logic is rising-edge
- wrst  input  1  reset, synchronous, active-high; one clock; reset is synchronous and active-high
- w_en  input  1  write request
- r2wptr  input  ADDRSIZE+1  read pointer, Gray coded, already synchronised into wclk
- af_thresh  input  ADDRSIZE+1  almost-full threshold in entries (0..2^ADDRSIZE); quasi-static
- ovf_clr  input  1  clears wovf
- waddr  output  ADDRSIZE  memory write address = wptr_bin[ADDRSIZE-1:0]
- wptr_gray  output  ADDRSIZE+1  registered Gray write pointer, sent to the read-domain synchroniser
- w_ack  output  1  combinational; w_en && !wfull; memory write strobe
- wfull  output  1  registered full flag
- walmost_full  output  1  registered; wlevel ≥ af_thresh
- wlevel  output  ADDRSIZE+1  registered occupancy as seen from the write side, 0..2^ADDRSIZE
- wovf  output  1  sticky overflow; a write was attempted while full

## Operation
- Internal wptr_bin is ADDRSIZE+1 bits. wbin_next = wptr_bin + w_ack, taken modulo 2^(ADDRSIZE+1), so the extra MSB toggles on each pass through the memory.
- wgray_next = (wbin_next >> 1) ^ wbin_next.
- rbin = Gray-to-binary of r2wptr, combinational: rbin[ADDRSIZE] = r2wptr[ADDRSIZE], and rbin[i] = rbin[i+1] ^ r2wptr[i].
- On every clock, when wrst = 0:
  - wptr_bin <= wbin_next
  - wptr_gray <= wgray_next
  - wfull <= (wgray_next == {~r2wptr[ADDRSIZE:ADDRSIZE-1], r2wptr[ADDRSIZE-2:0]})
  - wlevel <= (wbin_next − rbin), modulo 2^(ADDRSIZE+1)
  - walmost_full <= ((wbin_next − rbin) ≥ af_thresh)
- Writes while full are dropped. In that case w_ack = 0 and no state changes except wovf.
- wovf is set when w_en && wfull and is cleared when ovf_clr = 1. If both happen in the same cycle, set wins.
- Reading the FIFO only lowers the flags. The read-side path is pessimistic, so a stale r2wptr can over-report fullness but can never under-report it.

## Timing
- Reset values: wptr_bin 0, waddr 0, wptr_gray 0, wfull 0, walmost_full 0, wlevel 0, wovf 0. These apply regardless of af_thresh.
- Reset mid-operation: all state returns to the reset values on that edge, and the in-flight w_en is ignored. w_ack is forced to 0 while wrst = 1.
- Latency:
  - waddr and w_ack for the current write are valid in the same cycle.
  - wptr_gray, wfull, wlevel and walmost_full reflect that write on the next edge, with zero extra cycles.
  - A change on r2wptr is reflected in the flags one edge later.
- Simultaneous write and read-pointer advance: the flags use wbin_next and the current r2wptr together. If full with w_en = 1 and r2wptr advancing in the same cycle, the write is still dropped (wfull was 1) and wfull deasserts on the next edge.
- af_thresh = 0 gives walmost_full = 1 from the first edge after reset. af_thresh > 2^ADDRSIZE means walmost_full is never asserted.

## Test plan
- **Fill:** ADDRSIZE = 7, r2wptr = 0, reset, then 128 consecutive w_en. Required: waddr runs 0..127; on the edge of the 128th write, wfull = 1, wlevel = 128, wptr_gray = 8'hC0 and waddr = 0.
- **Overflow:** from the full state, 3 more w_en. Required: w_ack = 0, pointers unchanged, wovf = 1 and held. Then assert ovf_clr and w_en together while full: wovf stays 1. Then ovf_clr alone: wovf = 0.
- **Almost-full:** af_thresh = 100, write 99 entries then 1 more. Required: walmost_full = 0 at level 99 and 1 on the edge giving level 100. Moving r2wptr to Gray(5) then gives wlevel = 95 and walmost_full = 0 one edge later.
- **Wrap:** repeatedly write and advance r2wptr so that wptr_bin passes 255 → 0. Required: wptr_gray goes 8'h80 → 8'h00, wlevel stays correct modulo 256, and there is no false wfull.
- **Simultaneous:** when full, r2wptr goes from 0 to Gray(1) in the same cycle as w_en. Required: that write is dropped; next edge wfull = 0 and wlevel = 127; the following write is accepted and wfull = 1 again.
- **Reset mid-fill:** after 50 writes, assert wrst for one cycle with w_en = 1. Required: every output is at its reset value on that edge, and the next accepted write uses waddr = 0.
